// File: rtl/inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_queue : Thumb/Thumb-2 prefetch queue with fetch FSM and redirect     |
// | Optional same-cycle response bypass when IQ_BYPASS_EN is defined.         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module inst_queue #(
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);
  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH_HW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_mem [DEPTH_HW];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_addr, r_head_pc;
  logic          r_drop_low;

  logic          w_resp, w_byp, w_is32, w_valid, w_issue;
  logic [1:0]    w_in_n, w_pop_n, w_wr_n, w_qpop_n;
  logic [15:0]   w_in0, w_in1, w_h0, w_h1, w_wr0, w_wr1;
  logic [CW-1:0] w_avail;
  logic [PW-1:0] w_rd_ptr1, w_wr_ptr1;
  logic          w_unused;

  assign w_unused  = flush_addr[0];
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);

  // Accepted response halfwords; a mid-word redirect drops the low half once.
  assign w_resp = (r_state == ST_WAIT) && bus_rvalid && !flush;
  always_comb begin
    w_in_n = 2'd0;
    w_in0  = bus_rdata[15:0];
    w_in1  = bus_rdata[31:16];
    if (w_resp) begin
      if (r_drop_low) begin
        w_in_n = 2'd1;
        w_in0  = bus_rdata[31:16];
      end else begin
        w_in_n = 2'd2;
      end
    end
  end

`ifdef IQ_BYPASS_EN
  assign w_byp = w_resp && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_h0    = w_byp ? w_in0 : r_mem[r_rd_ptr];
  assign w_h1    = w_byp ? w_in1 : r_mem[w_rd_ptr1];
  assign w_avail = w_byp ? CW'(w_in_n) : r_count;
  assign w_is32  = (w_h0[15:13] == 3'b111) && (w_h0[12:11] != 2'b00);
  assign w_valid = !flush && (w_is32 ? (w_avail >= CW'(2)) : (w_avail >= CW'(1)));
  assign w_pop_n = (w_valid && inst_ready) ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;

  // Bypassed halfwords that were consumed are never written to the ring.
  always_comb begin
    w_wr_n   = w_in_n;
    w_wr0    = w_in0;
    w_wr1    = w_in1;
    w_qpop_n = w_pop_n;
    if (w_byp) begin
      w_qpop_n = 2'd0;
      w_wr_n   = w_in_n - w_pop_n;
      if (w_pop_n == 2'd1) w_wr0 = w_in1;
    end
  end

  assign w_issue = rst && (r_state == ST_IDLE) && !flush && ((C_DEPTH - r_count) >= CW'(2));

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = (r_state != ST_IDLE && !bus_rvalid) ? ST_DISCARD : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_issue)    w_state_next = ST_WAIT;
        ST_WAIT:    if (bus_rvalid) w_state_next = ST_IDLE;
        ST_DISCARD: if (bus_rvalid) w_state_next = ST_IDLE;
        default:                    w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_head_pc    <= {RESET_PC[31:1], 1'b0};
      r_drop_low   <= RESET_PC[1];
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_fetch_addr <= {flush_addr[31:2], 2'b00};
        r_head_pc    <= {flush_addr[31:1], 1'b0};
        r_drop_low   <= flush_addr[1];
      end else begin
        r_wr_ptr  <= r_wr_ptr + PW'(w_wr_n);
        r_rd_ptr  <= r_rd_ptr + PW'(w_qpop_n);
        r_count   <= r_count + CW'(w_wr_n) - CW'(w_qpop_n);
        r_head_pc <= r_head_pc + {29'd0, w_pop_n, 1'b0};
        if (w_resp) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
          r_drop_low   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_n != 2'd0) r_mem[r_wr_ptr]  <= w_wr0;
    if (w_wr_n == 2'd2) r_mem[w_wr_ptr1] <= w_wr1;
  end

  assign bus_req    = w_issue;
  assign bus_addr   = w_issue ? r_fetch_addr : 32'h0;
  assign inst_valid = w_valid;
  assign inst_is32  = w_valid && w_is32;
  assign inst_pc    = w_valid ? r_head_pc : 32'h0;
  assign inst       = !w_valid ? 32'h0 : (w_is32 ? {w_h0, w_h1} : {16'h0, w_h0});

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// Testbench for inst_queue: directed scenarios plus random traffic checked
// against a halfword-queue reference model.
module tb_inst_queue;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_rdata = 32'h0;
  logic        flush = 1'b0, inst_ready = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic [31:0] inst, inst_pc;
  logic        inst_is32, inst_valid;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH_HW(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .flush(flush),
    .flush_addr(flush_addr), .inst(inst), .inst_is32(inst_is32),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // memory image and single-outstanding responder
  logic [15:0] mem [256];
  bit          pend = 0;
  int          lat = 0, lat_min = 1, lat_max = 3;
  logic [31:0] pend_data;

  function automatic logic [31:0] rdata_at(input logic [31:0] a);
    int i;
    i = int'(a >> 1);
    return {mem[(i + 1) & 255], mem[i & 255]};
  endfunction

  // reference model: pending halfwords as a queue
  logic [15:0] mq[$];
  logic [31:0] m_pc, m_fetch;
  bit          m_drop;
  int          m_st;  // 0 idle, 1 waiting, 2 discarding

  logic [31:0] acc_pc[$], acc_inst[$], req_log[$];
  bit          acc_32[$];
  bit          rv_armed = 0, rv_obs = 0;

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic cycle(input bit fl, input logic [31:0] fa, input bit rdy);
    logic [15:0] inc[$];
    logic [15:0] view[$];
    bit          e_req, e_val, e_32, byp;
    logic [31:0] e_inst;
    int          npop;
    @(negedge clk);
    rst        = 1'b1;
    bus_rvalid = 1'b0;
    if (pend) begin
      lat--;
      if (lat <= 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = pend_data;
        pend       = 0;
      end
    end
    flush      = fl && !bus_rvalid;
    flush_addr = fa;
    inst_ready = rdy;
    #1;
    inc.delete();
    if (m_st == 1 && bus_rvalid && !flush) begin
      if (m_drop) inc.push_back(bus_rdata[31:16]);
      else begin
        inc.push_back(bus_rdata[15:0]);
        inc.push_back(bus_rdata[31:16]);
      end
    end
    byp = 0;
`ifdef IQ_BYPASS_EN
    byp = (mq.size() == 0) && (inc.size() > 0);
`endif
    view   = byp ? inc : mq;
    e_val  = 0;
    e_32   = 0;
    e_inst = 32'h0;
    if (!flush && view.size() >= 1) begin
      e_32 = (view[0][15:11] >= 5'b11101);
      if (!e_32) begin
        e_val  = 1;
        e_inst = {16'h0, view[0]};
      end else if (view.size() >= 2) begin
        e_val  = 1;
        e_inst = {view[0], view[1]};
      end
    end
    if (!e_val) e_32 = 0;
    e_req = (m_st == 0) && !flush && ((DEPTH - mq.size()) >= 2);

    check("bus_req", 32'(bus_req), 32'(e_req));
    if (e_req) check("bus_addr", bus_addr, m_fetch);
    check("inst_valid", 32'(inst_valid), 32'(e_val));
    if (e_val) begin
      check("inst_is32", 32'(inst_is32), 32'(e_32));
      check("inst", inst, e_inst);
      check("inst_pc", inst_pc, m_pc);
    end
    if (rv_armed && bus_rvalid && m_st == 1) begin
      rv_obs   = inst_valid;
      rv_armed = 0;
    end
    if (inst_valid && inst_ready) begin
      acc_pc.push_back(inst_pc);
      acc_inst.push_back(inst);
      acc_32.push_back(inst_is32);
    end
    if (bus_req) begin
      req_log.push_back(bus_addr);
      pend      = 1;
      pend_data = rdata_at(bus_addr);
      lat       = $urandom_range(lat_min, lat_max);
    end

    npop = (e_val && rdy) ? (e_32 ? 2 : 1) : 0;
    if (flush) begin
      mq.delete();
      m_pc    = fa & ~32'd1;
      m_fetch = fa & ~32'd3;
      m_drop  = fa[1];
      m_st    = (m_st != 0) ? 2 : 0;
    end else begin
      if (inc.size() > 0) begin
        m_fetch += 4;
        m_drop   = 0;
      end
      if (byp) mq = inc;
      repeat (npop) void'(mq.pop_front());
      if (!byp) foreach (inc[i]) mq.push_back(inc[i]);
      m_pc += 32'(2 * npop);
      if (e_req) m_st = 1;
      else if (m_st != 0 && bus_rvalid) m_st = 0;
    end
  endtask

  task automatic do_reset(input bit keep_pend);
    @(posedge clk);
    #2;
    rst        = 1'b0;
    flush      = 1'b0;
    bus_rvalid = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("rst bus_req", 32'(bus_req), 32'h0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst inst", inst, 32'h0);
    check("rst inst_is32", 32'(inst_is32), 32'h0);
    check("rst inst_pc", inst_pc, 32'h0);
    check("rst inst_valid", 32'(inst_valid), 32'h0);
    mq.delete();
    m_pc    = RPC & ~32'd1;
    m_fetch = RPC & ~32'd3;
    m_drop  = RPC[1];
    m_st    = 0;
    if (!keep_pend) pend = 0;
    acc_pc.delete();
    acc_inst.delete();
    acc_32.delete();
    req_log.delete();
  endtask

  initial begin
    // 1: two 16-bit instructions from one word; also response-to-valid latency
    fill_mem(16'hBF00);
    mem[0] = 16'h2001;
    mem[1] = 16'hBF00;
    lat_min = 1; lat_max = 1;
    do_reset(0);
    rv_armed = 1;
    repeat (8) cycle(0, 0, 1);
    check("t1 count", 32'(acc_pc.size() >= 2), 32'h1);
    check("t1 i0", acc_inst[0], 32'h0000_2001);
    check("t1 pc0", acc_pc[0], 32'h0);
    check("t1 i1", acc_inst[1], 32'h0000_BF00);
    check("t1 pc1", acc_pc[1], 32'h2);
    check("t1 is32", 32'(acc_32[1]), 32'h0);
`ifdef IQ_BYPASS_EN
    check("t7 bypass valid", 32'(rv_obs), 32'h1);
`else
    check("t7 no-bypass valid", 32'(rv_obs), 32'h0);
`endif

    // 2: one 32-bit instruction in one word
    fill_mem(16'hBF00);
    mem[0] = 16'hF000;
    mem[1] = 16'hF800;
    do_reset(0);
    repeat (8) cycle(0, 0, 1);
    check("t2 i0", acc_inst[0], 32'hF000_F800);
    check("t2 is32", 32'(acc_32[0]), 32'h1);
    check("t2 pc0", acc_pc[0], 32'h0);
    check("t2 addr1", req_log[1], 32'h4);

    // 3: 32-bit instruction straddling two words
    fill_mem(16'hBF00);
    mem[0] = 16'h2001; mem[1] = 16'hF000; mem[2] = 16'hF800; mem[3] = 16'h4770;
    lat_min = 2; lat_max = 2;
    do_reset(0);
    repeat (12) cycle(0, 0, 1);
    check("t3 i0", acc_inst[0], 32'h0000_2001);
    check("t3 i1", acc_inst[1], 32'hF000_F800);
    check("t3 pc1", acc_pc[1], 32'h2);
    check("t3 i2", acc_inst[2], 32'h0000_4770);
    check("t3 pc2", acc_pc[2], 32'h6);

    // 4: back-pressure fills the ring
    fill_mem(16'hBF00);
    lat_min = 1; lat_max = 1;
    do_reset(0);
    repeat (14) cycle(0, 0, 0);
    check("t4 reqs", 32'(req_log.size()), 32'd4);
    check("t4 last addr", req_log[3], 32'hC);
    repeat (6) cycle(0, 0, 1);
    check("t4 refetch", 32'(req_log.size() > 4), 32'h1);

    // 5: redirect while a request is outstanding
    fill_mem(16'hBF00);
    lat_min = 3; lat_max = 3;
    do_reset(0);
    cycle(0, 0, 1);
    mem[8'h80] = 16'h2001;
    mem[8'h81] = 16'h4770;
    cycle(1, 32'h102, 1);
    repeat (10) cycle(0, 0, 1);
    check("t5 addr", req_log[1], 32'h100);
    check("t5 i0", acc_inst[0], 32'h0000_4770);
    check("t5 pc0", acc_pc[0], 32'h102);

    // 6: reset while waiting; stale response lands right after release
    fill_mem(16'hBF00);
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    lat_min = 4; lat_max = 4;
    do_reset(0);
    cycle(0, 0, 1);
    mem[0] = 16'h3333; mem[1] = 16'h4444;
    do_reset(1);
    lat = 1;
    lat_min = 2; lat_max = 2;
    repeat (8) cycle(0, 0, 1);
    check("t6 addr", req_log[0], RPC);
    check("t6 i0", acc_inst[0], 32'h0000_3333);

    // random traffic
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 9);
      mem[i] = (r < 3) ? {3'b111, 2'(r + 1), 11'($urandom)} : 16'($urandom);
    end
    lat_min = 1; lat_max = 4;
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      bit          fl, rdy;
      logic [31:0] fa;
      fl  = ($urandom_range(0, 29) == 0);
      fa  = 32'($urandom_range(0, 255)) << 1;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(fl, fa, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
